// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store bridge between the multi-cycle
// controller and a valid/ready request, valid response data bus.
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memu_valid,
   input  logic        DMre,
   input  logic        DMwe,
   input  logic [63:0] addr,
   input  logic [63:0] wdata,
   output logic        memu_finish,
   output logic [63:0] rdata,
   output logic        misalign,
   output logic        bus_err,
   output logic        dreq_valid,
   input  logic        dreq_ready,
   output logic [63:0] dreq_addr,
   output logic        dreq_write,
   output logic [63:0] dreq_wdata,
   input  logic        dresp_valid,
   input  logic [63:0] dresp_data,
   input  logic        dresp_err
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t state;
   logic [15:0] cnt;
   logic one_cmd, go_bus, expired;
   assign one_cmd = DMre ^ DMwe;
   assign go_bus  = one_cmd && addr[2:0] == 3'b0;
   // cnt holds the number of REQ/WAIT cycles already completed
   assign expired = cnt >= LAST;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         memu_finish <= 1'b0;
         rdata       <= '0;
         misalign    <= 1'b0;
         bus_err     <= 1'b0;
         dreq_valid  <= 1'b0;
         dreq_addr   <= '0;
         dreq_write  <= 1'b0;
         dreq_wdata  <= '0;
      end else begin
         memu_finish <= 1'b0;
         case (state)
            IDLE: if (memu_valid) begin
               dreq_addr   <= addr;
               dreq_write  <= DMwe;
               dreq_wdata  <= DMwe ? wdata : '0;
               misalign    <= one_cmd && addr[2:0] != 3'b0;
               bus_err     <= DMre && DMwe;
               cnt         <= '0;
               dreq_valid  <= go_bus;
               memu_finish <= !go_bus;
               state       <= go_bus ? REQ : DONE;
            end
            REQ: begin
               cnt <= cnt + 16'd1;
               if (dreq_ready) begin
                  dreq_valid <= 1'b0;
                  state      <= WAIT;
               end else if (expired) begin
                  dreq_valid  <= 1'b0;
                  bus_err     <= 1'b1;
                  memu_finish <= 1'b1;
                  state       <= DONE;
               end
            end
            WAIT: begin
               cnt <= cnt + 16'd1;
               if (dresp_valid) begin
                  bus_err     <= dresp_err;
                  memu_finish <= 1'b1;
                  state       <= DONE;
                  if (!dreq_write && !dresp_err) rdata <= dresp_data;
               end else if (expired) begin
                  bus_err     <= 1'b1;
                  memu_finish <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against
// a transaction-level latency/result model.
module tb_mem_access_unit;
   localparam int TT = 4;
   logic clk = 0, rst = 0;
   logic memu_valid = 0, DMre = 0, DMwe = 0, dreq_ready = 0, dresp_valid = 0, dresp_err = 0;
   logic [63:0] addr = '0, wdata = '0, dresp_data = '0;
   logic memu_finish, misalign, bus_err, dreq_valid, dreq_write;
   logic [63:0] rdata, dreq_addr, dreq_wdata;
   logic memu_finish_t, misalign_t, bus_err_t, dreq_valid_t, dreq_write_t;
   logic [63:0] rdata_t, dreq_addr_t, dreq_wdata_t;
   int checks = 0, errors = 0;
   logic [63:0] exp_rdata = '0;

   mem_access_unit dut (
      .clk(clk), .rst(rst), .memu_valid(memu_valid), .DMre(DMre), .DMwe(DMwe),
      .addr(addr), .wdata(wdata), .memu_finish(memu_finish), .rdata(rdata),
      .misalign(misalign), .bus_err(bus_err), .dreq_valid(dreq_valid),
      .dreq_ready(dreq_ready), .dreq_addr(dreq_addr), .dreq_write(dreq_write),
      .dreq_wdata(dreq_wdata), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
      .dresp_err(dresp_err));

   mem_access_unit #(.TIMEOUT_CYCLES(TT)) dut_t (
      .clk(clk), .rst(rst), .memu_valid(memu_valid), .DMre(DMre), .DMwe(DMwe),
      .addr(addr), .wdata(wdata), .memu_finish(memu_finish_t), .rdata(rdata_t),
      .misalign(misalign_t), .bus_err(bus_err_t), .dreq_valid(dreq_valid_t),
      .dreq_ready(dreq_ready), .dreq_addr(dreq_addr_t), .dreq_write(dreq_write_t),
      .dreq_wdata(dreq_wdata_t), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
      .dresp_err(dresp_err));

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 0;
      repeat (3) @(negedge clk);
      checks++;
      if ({memu_finish, rdata, misalign, bus_err, dreq_valid, dreq_addr, dreq_write, dreq_wdata} !== '0) begin
         errors++;
         $display("FAIL reset outputs got fin=%b rdata=%h mis=%b err=%b dv=%b da=%h dw=%b dwd=%h want all 0",
                  memu_finish, rdata, misalign, bus_err, dreq_valid, dreq_addr, dreq_write, dreq_wdata);
      end
      rst = 1;
      exp_rdata = '0;
   endtask

   // One access on the default-timeout unit; rd = REQ cycles before ready, rsd = WAIT cycles before response.
   task automatic access(input string name, input logic re, input logic we, input logic [63:0] a,
                         input logic [63:0] wd, input int rd, input int rsd, input logic err,
                         input logic [63:0] rdat);
      logic legal, mis, bus, exp_be;
      int lat, nr;
      logic [63:0] wexp;
      legal = re ^ we;
      mis = legal && a[2:0] != 3'b0;
      bus = legal && !mis;
      nr = rd + rsd + 2;
      lat = bus ? nr + 1 : 1;
      exp_be = (re && we) || (bus && err);
      wexp = we ? wd : 64'd0;
      if (bus && re && !err) exp_rdata = rdat;
      memu_valid = 1; DMre = re; DMwe = we; addr = a; wdata = wd;
      for (int n = 1; n <= lat + 1; n++) begin
         @(negedge clk);
         checks++;
         if (memu_finish !== (n == lat)) begin
            errors++;
            $display("FAIL %s finish cycle %0d got %b want %b", name, n, memu_finish, n == lat);
         end
         checks++;
         if (dreq_valid !== (bus && n <= rd + 1)) begin
            errors++;
            $display("FAIL %s dreq_valid cycle %0d got %b want %b", name, n, dreq_valid, bus && n <= rd + 1);
         end
         if (bus && n <= rd + 1) begin
            checks++;
            if (dreq_addr !== a || dreq_write !== we || dreq_wdata !== wexp) begin
               errors++;
               $display("FAIL %s payload cycle %0d got %h/%b/%h want %h/%b/%h", name, n,
                        dreq_addr, dreq_write, dreq_wdata, a, we, wexp);
            end
         end
         if (n == lat + 1) begin
            checks++;
            if (rdata !== exp_rdata || misalign !== mis || bus_err !== exp_be) begin
               errors++;
               $display("FAIL %s result got rdata=%h mis=%b err=%b want rdata=%h mis=%b err=%b", name,
                        rdata, misalign, bus_err, exp_rdata, mis, exp_be);
            end
         end
         memu_valid = (n <= lat) ? 1'($urandom % 2) : 1'b0;
         DMre = 1; DMwe = 1;
         dreq_ready = (bus && n <= rd + 1) ? (n == rd + 1) : 1'($urandom % 2);
         dresp_valid = (bus && n >= rd + 2 && n <= nr) ? (n == nr) : 1'($urandom % 2);
         dresp_data = (bus && n == nr) ? rdat : {$urandom, $urandom};
         dresp_err = (bus && n == nr) ? err : 1'($urandom % 2);
      end
      memu_valid = 0; dreq_ready = 0; dresp_valid = 0; dresp_err = 0;
   endtask

   task automatic test_directed();
      access("rd_basic", 1, 0, 64'h8000_0010, 64'h0, 0, 0, 0, 64'hDEADBEEF_CAFEF00D);
      access("wr_stall", 0, 1, 64'h8000_0008, 64'h1122334455667788, 4, 0, 0, 64'h5555);
      access("misalign", 1, 0, 64'h8000_0003, 64'h0, 0, 0, 0, 64'h0);
      access("realign", 0, 1, 64'h8000_0018, 64'hA5A5, 1, 2, 0, 64'h0);
      access("rd_err", 1, 0, 64'h8000_0020, 64'h0, 0, 1, 1, 64'hBAD0_BAD0);
      access("both_set", 1, 1, 64'h8000_0028, 64'h0, 0, 0, 0, 64'h0);
      access("none_set", 0, 0, 64'h8000_0030, 64'h0, 0, 0, 0, 64'h0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         int k;
         logic re, we;
         logic [63:0] a;
         k = int'($urandom % 8);
         re = (k == 0) || (k >= 2 && k < 5);
         we = (k == 0) || (k >= 5);
         a = {32'h8000_0000, $urandom};
         if ($urandom % 4 != 0) a[2:0] = 3'b0;
         access("random", re, we, a, {$urandom, $urandom}, int'($urandom % 5), int'($urandom % 5),
                1'($urandom % 4 == 0), {$urandom, $urandom});
      end
   endtask

   // Aligned read on the TT-cycle unit; rd/rsd as in access, large rd means ready never comes.
   task automatic run_t(input string name, input int rd, input int rsd, input logic err);
      int nr, ext, hs_end, ab;
      logic hs, ok;
      logic [63:0] d;
      int fins;
      d = {$urandom, $urandom};
      rst = 0;
      @(negedge clk);
      rst = 1;
      nr = rd + rsd + 2;
      hs = rd + 1 <= TT;
      ab = hs ? ((rd + 2 > TT) ? rd + 2 : TT) : TT;
      ok = hs && nr <= ab;
      ext = ok ? nr : ab;
      hs_end = hs ? rd + 1 : TT;
      fins = 0;
      memu_valid = 1; DMre = 1; DMwe = 0; addr = 64'h8000_0040;
      for (int n = 1; n <= ext + 3; n++) begin
         @(negedge clk);
         fins += int'(memu_finish_t);
         checks++;
         if (memu_finish_t !== (n == ext + 1)) begin
            errors++;
            $display("FAIL %s finish cycle %0d got %b want %b", name, n, memu_finish_t, n == ext + 1);
         end
         checks++;
         if (dreq_valid_t !== (n <= hs_end)) begin
            errors++;
            $display("FAIL %s dreq_valid cycle %0d got %b want %b", name, n, dreq_valid_t, n <= hs_end);
         end
         memu_valid = 0;
         dreq_ready = (n == rd + 1);
         dresp_valid = (n == nr);
         dresp_data = d;
         dresp_err = err;
      end
      dreq_ready = 0; dresp_valid = 0; dresp_err = 0;
      checks++;
      if (fins != 1 || bus_err_t !== (!ok || err) || rdata_t !== ((ok && !err) ? d : 64'd0)) begin
         errors++;
         $display("FAIL %s result got fins=%0d err=%b rdata=%h want fins=1 err=%b rdata=%h", name, fins,
                  bus_err_t, rdata_t, !ok || err, (ok && !err) ? d : 64'd0);
      end
   endtask

   task automatic test_timeout();
      run_t("to_stuck", 1000, 0, 0);
      run_t("to_race_hs", 3, 0, 0);
      run_t("to_wait_abort", 3, 1, 0);
      run_t("to_resp_at_limit", 1, 1, 0);
      run_t("to_long_wait", 1, 5, 0);
      run_t("to_err", 0, 1, 1);
   endtask

   task automatic test_mid_reset();
      int fins;
      rst = 0;
      @(negedge clk);
      rst = 1;
      exp_rdata = '0;
      memu_valid = 1; DMre = 1; DMwe = 0; addr = 64'h8000_0050;
      @(negedge clk);
      memu_valid = 0; dreq_ready = 1;
      @(negedge clk);
      dreq_ready = 0;
      rst = 0;
      #1;
      checks++;
      if ({memu_finish, rdata, misalign, bus_err, dreq_valid, dreq_addr, dreq_write, dreq_wdata} !== '0) begin
         errors++;
         $display("FAIL mid_reset async clear got fin=%b rdata=%h dv=%b da=%h want all 0",
                  memu_finish, rdata, dreq_valid, dreq_addr);
      end
      @(negedge clk);
      rst = 1;
      fins = 0;
      for (int n = 0; n < 5; n++) begin
         dresp_valid = 1; dresp_data = {$urandom, $urandom}; dresp_err = 0;
         @(negedge clk);
         fins += int'(memu_finish);
      end
      dresp_valid = 0;
      checks++;
      if (fins != 0 || rdata !== 64'd0 || bus_err !== 1'b0 || dreq_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset late_resp got fins=%0d rdata=%h err=%b dv=%b want 0", fins, rdata, bus_err, dreq_valid);
      end
      access("post_reset_both", 1, 1, 64'h8000_0058, 64'h0, 0, 0, 0, 64'h0);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
